slave_mem_responder: RTL and testbench
======================================

// Module: slave_mem_responder
// PURPOSE
//  Memory-backed responder for one crossbar slave port: the target end of slave_if.
//  Accepts requests driven by the crossbar (req/cmd/addr/wdata), acknowledges them
//  with programmable wait states, writes or reads a local word array and returns
//  read data after a fixed latency. One instance per slave port in the demo top and
//  bench; also the reference target model for crossbar routing checks.
// PARAMETERS
//  ADDR_W    30  slave address width; 32-$clog2(N) for an N-port crossbar
//  MEM_AW    8   index width of the word array (2**MEM_AW x 32b)
//  ACK_WAIT  0   extra cycles req must be held before ack (0..15)
//  READ_LAT  2   cycles from ack-high cycle to resp-high cycle (1..8)
//  MAX_OUTST 4   max reads accepted but not yet responded (1..8)
// PORTS
//  clk    in   1       clock, all logic on rising edge
//  rst    in   1       asynchronous reset, active-low
//  req    in   1       request, held high by the crossbar until ack is seen
//  cmd    in   1       1 = write, 0 = read; sampled at accept edge
//  addr   in   ADDR_W  word address; sampled at accept edge
//  wdata  in   32      write data; sampled at accept edge
//  ack    out  1       one-cycle accept pulse
//  resp   out  1       one-cycle read-response pulse; rdata valid while high
//  rdata  out  32      read data
// BEHAVIOUR
//  Reset (rst low, async): ack=0, resp=0, rdata=0, FSM=IDLE, wait count=0,
//   delay line and outstanding count cleared. Memory array is not reset.
//  Accept FSM: IDLE -> WAIT -> ACK -> IDLE.
//   IDLE: req=1 -> WAIT with wait count 0 (ACK_WAIT=0: WAIT resolves on next edge).
//   WAIT: req=0 -> IDLE (abandoned, no ack). req=1 & count<ACK_WAIT -> count+1.
//         req=1 & count==ACK_WAIT & (cmd=1 | outstanding<MAX_OUTST) -> accept:
//         sample cmd/addr/wdata, ack<=1, -> ACK. Read with outstanding full: stall.
//   ACK: ack<=0 unconditionally, -> IDLE. No back-to-back acks; peak rate 1/3 clk
//        at ACK_WAIT=0 (req edge, accept edge, ack cycle).
//  Address decode: addr[ADDR_W-1:MEM_AW]!=0 is out of range: write dropped,
//   read returns BAD_ADDR_DATA (32'hDEAD_BEEF). In range: index addr[MEM_AW-1:0].
//  Write: array updated at accept edge; no resp. A read accepted later sees it.
//  Read: data fetched at accept edge into READ_LAT-stage delay line; ack high in
//   cycle k -> resp=1 and rdata=data in cycle k+READ_LAT, resp=0 after.
//   rdata holds last returned value when resp=0.
//  Outstanding: +1 on read accept, -1 on resp; simultaneous -> unchanged.
//   Responses strictly in acceptance order.
//  req dropped while in WAIT clears wait count; cmd/addr changes before accept
//   are harmless (only accept-edge values used).
//  Reset mid-transaction: in-flight reads discarded, no resp after release.
// STRUCTURE
//  crossbar_pkg: CMD_READ=1'b0, CMD_WRITE=1'b1, BAD_ADDR_DATA, acc_state_e
//   {IDLE,WAIT,ACK}.
//  Sub-module rd_delay_line (params LAT, W=32): valid+data shift pipe, async
//   active-low reset on valid bits; FSM, decode, array, counter in top.
// TESTING
//  1 Defaults: write 0x5 <- 0xA5A5_0001, then read 0x5 -> ack 1 cycle each,
//    resp 2 cycles after read ack with rdata=0xA5A5_0001; no resp for write.
//  2 ACK_WAIT=3: req held -> ack exactly 4 edges after req seen; req dropped after
//    2 cycles -> no ack, re-raised -> full 3-cycle wait again.
//  3 Read addr 0x100 (MEM_AW=8) -> resp with 0xDEAD_BEEF; write there -> array
//    unchanged (read 0x00 returns prior value).
//  4 READ_LAT=8, MAX_OUTST=2, req held for 4 reads -> 2 acks, stall until first
//    resp, then resume; 4 resps in order, counter never exceeds 2.
//  5 rst low 1 cycle after read ack -> ack/resp/rdata 0 immediately, no resp
//    ever for that read; next read after release behaves as scenario 1.
//  6 Random req/cmd/addr vs scoreboard array model: data and order match.

Source files
------------

// File: rtl/crossbar_pkg.sv
// Shared command encodings, bad-address fill pattern and accept-FSM states
// for crossbar slave-port targets.
package crossbar_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic [31:0] BAD_ADDR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/rd_delay_line.sv
// Fixed-latency valid+data shift pipe carrying read data from accept to response.
// Only the valid bits are reset; data stages are don't-care while invalid.
module rd_delay_line #(
  parameter int LAT = 2,
  parameter int W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LAT-1:0] valid_reg;
  logic [LAT-1:0] valid_next;
  logic [W-1:0]   data_reg  [LAT];
  logic [W-1:0]   data_next [LAT];

  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      assign valid_next[gi] = in_valid;
      assign data_next[gi]  = in_data;
    end else begin : g_tail
      assign valid_next[gi] = valid_reg[gi-1];
      assign data_next[gi]  = data_reg[gi-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  always_ff @(posedge clk) begin
    data_reg <= data_next;
  end

  assign out_valid = valid_reg[LAT-1];
  assign out_data  = data_reg[LAT-1];

endmodule

// File: rtl/slave_mem_responder.sv
// Memory-backed target for one crossbar slave port: wait-state accept FSM,
// local word array, in-order read responses after a fixed latency.
module slave_mem_responder
  import crossbar_pkg::*;
#(
  parameter int ADDR_W    = 30,
  parameter int MEM_AW    = 8,
  parameter int ACK_WAIT  = 0,
  parameter int READ_LAT  = 2,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic              resp,
  output logic [31:0]       rdata
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(ACK_WAIT);
  localparam logic [CNT_W-1:0] OUTST_MAX = CNT_W'(MAX_OUTST);

  acc_state_e       state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             ack_reg, ack_next;
  logic [CNT_W-1:0] outst_reg;
  logic             resp_reg;
  logic [31:0]      rdata_reg;

  logic              accept;
  logic              rd_accept;
  logic              wr_accept;
  logic              in_range;
  logic [MEM_AW-1:0] index;
  logic [31:0]       rd_word;
  logic              line_valid;
  logic [31:0]       line_data;

  logic [31:0] mem [2**MEM_AW];

  assign in_range = (addr >> MEM_AW) == '0;
  assign index    = addr[MEM_AW-1:0];

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    ack_next      = 1'b0;
    accept        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next    = WAIT;
          wait_cnt_next = '0;
        end
      end
      WAIT: begin
        if (!req) begin
          state_next    = IDLE;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg < WAIT_MAX) begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end else if (cmd == CMD_WRITE || outst_reg < OUTST_MAX) begin
          // Reads stall here while the response pipe is full.
          accept        = 1'b1;
          ack_next      = 1'b1;
          state_next    = ACK;
          wait_cnt_next = '0;
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rd_accept = accept && (cmd == CMD_READ);
  assign wr_accept = accept && (cmd == CMD_WRITE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      ack_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      ack_reg      <= ack_next;
    end
  end

  // Array is deliberately not reset; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_accept && in_range) begin
      mem[index] <= wdata;
    end
  end

  assign rd_word = in_range ? mem[index] : BAD_ADDR_DATA;

  rd_delay_line #(
    .LAT (READ_LAT),
    .W   (32)
  ) u_rd_line (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_accept),
    .in_data   (rd_word),
    .out_valid (line_valid),
    .out_data  (line_data)
  );

  // The output register adds the final cycle, so resp lands READ_LAT after ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_reg  <= 1'b0;
      rdata_reg <= '0;
      outst_reg <= '0;
    end else begin
      resp_reg <= line_valid;
      if (line_valid) begin
        rdata_reg <= line_data;
      end
      case ({rd_accept, resp_reg})
        2'b10:   outst_reg <= outst_reg + 1'b1;
        2'b01:   outst_reg <= outst_reg - 1'b1;
        default: outst_reg <= outst_reg;
      endcase
    end
  end

  assign ack   = ack_reg;
  assign resp  = resp_reg;
  assign rdata = rdata_reg;

endmodule

// File: tb/tb_slave_mem_responder.sv
// Bench for slave_mem_responder: three instances (default, long wait, long latency
// with shallow outstanding limit) driven by vector table, corner sequences and random streams.
module tb_slave_mem_responder;

  localparam logic        RD  = 1'b0;
  localparam logic        WR  = 1'b1;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  typedef struct {
    int          inst;
    logic        c;
    logic [29:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          known;
  } pend_t;

  logic        clk;
  logic        rst;
  logic        req   [3];
  logic        cmd   [3];
  logic [29:0] addr  [3];
  logic [31:0] wdata [3];
  logic        ack   [3];
  logic        resp  [3];
  logic [31:0] rdata [3];

  int vectors;
  int miscompares;

  logic [31:0] model_mem   [3][256];
  bit          model_known [3][256];

  vec_t tbl [14];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    slave_mem_responder #(
      .ADDR_W    (30),
      .MEM_AW    (8),
      .ACK_WAIT  (gi == 1 ? 3 : 0),
      .READ_LAT  (gi == 2 ? 8 : 2),
      .MAX_OUTST (gi == 2 ? 2 : 4)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req[gi]),
      .cmd   (cmd[gi]),
      .addr  (addr[gi]),
      .wdata (wdata[gi]),
      .ack   (ack[gi]),
      .resp  (resp[gi]),
      .rdata (rdata[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  function automatic int ackw(input int i);
    return (i == 1) ? 3 : 0;
  endfunction

  function automatic int latc(input int i);
    return (i == 2) ? 8 : 2;
  endfunction

  function automatic int maxo(input int i);
    return (i == 2) ? 2 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_true(input string name, input bit cond);
    vectors++;
    if (!cond) begin
      miscompares++;
      $display("FAIL %s: condition got 0 want 1", name);
    end
  endtask

  function automatic logic [31:0] model_read(input int i, input logic [29:0] a);
    return ((a >> 8) == 0) ? model_mem[i][a[7:0]] : BAD;
  endfunction

  function automatic bit model_known_at(input int i, input logic [29:0] a);
    return ((a >> 8) != 0) || model_known[i][a[7:0]];
  endfunction

  task automatic model_write(input int i, input logic [29:0] a, input logic [31:0] d);
    if ((a >> 8) == 0) begin
      model_mem[i][a[7:0]]   = d;
      model_known[i][a[7:0]] = 1'b1;
    end
  endtask

  // Single transaction: checks ack latency, one-cycle ack, resp timing and data hold.
  task automatic do_txn(input int i, input logic c, input logic [29:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input string tag);
    int lat;
    int nresp;
    @(negedge clk);
    req[i] = 1'b1; cmd[i] = c; addr[i] = a; wdata[i] = d;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!ack[i] && lat < 64);
    req[i] = 1'b0;
    check({tag, " ack_lat"}, lat, ackw(i) + 2);
    if (c == WR) model_write(i, a, d);
    nresp = 0;
    for (int n = 1; n <= latc(i) + 3; n++) begin
      @(posedge clk); #1;
      if (n == 1) check({tag, " ack_pulse"}, 32'(ack[i]), 0);
      if (resp[i]) begin
        nresp++;
        if (c == RD) begin
          check({tag, " resp_lat"}, n, latc(i));
          check({tag, " rdata"}, rdata[i], exp_rd);
        end
      end
      if (c == RD && n == latc(i) + 1) check({tag, " rdata_hold"}, rdata[i], exp_rd);
    end
    check({tag, " resp_count"}, nresp, (c == RD) ? 1 : 0);
  endtask

  task automatic pick(input bit rnd, input int k, output logic c, output logic [29:0] a,
                      output logic [31:0] d);
    if (!rnd) begin
      c = RD;
      a = (k % 2 == 0) ? 30'h003 : 30'h100;
      d = '0;
    end else begin
      c = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 30'($urandom) | 30'h100;
      else a = 30'($urandom_range(0, 15));
      d = $urandom;
    end
  endtask

  // Pipelined stream with a scoreboard queue of expected responses.
  task automatic run_stream(input int i, input int ntx, input bit rnd,
                            output int max_o, output int ack3_cyc, output int resp1_cyc);
    pend_t       q[$];
    pend_t       p;
    int          cyc, acc, outst;
    bit          prev_ack;
    logic        c;
    logic [29:0] a;
    logic [31:0] d;
    cyc = 0; acc = 0; outst = 0; prev_ack = 1'b0;
    max_o = 0; ack3_cyc = -1; resp1_cyc = -1;
    pick(rnd, acc, c, a, d);
    @(negedge clk);
    req[i] = 1'b1; cmd[i] = c; addr[i] = a; wdata[i] = d;
    while ((acc < ntx || q.size() != 0) && cyc < 8000) begin
      @(posedge clk); #1; cyc++;
      if (ack[i]) begin
        check_true($sformatf("i%0d ack_single cyc%0d", i, cyc), !prev_ack);
        check($sformatf("i%0d ack_with_req", i), 32'(req[i]), 1);
        acc++;
        if (acc == 3) ack3_cyc = cyc;
        if (cmd[i] == WR) begin
          model_write(i, addr[i], wdata[i]);
        end else begin
          p.due   = cyc + latc(i);
          p.data  = model_read(i, addr[i]);
          p.known = model_known_at(i, addr[i]);
          q.push_back(p);
          outst++;
          if (outst > max_o) max_o = outst;
          check_true($sformatf("i%0d outst_limit %0d", i, outst), outst <= maxo(i));
        end
        if (acc < ntx && (!rnd || $urandom_range(0, 1) == 1)) begin
          pick(rnd, acc, c, a, d);
          req[i] = 1'b1; cmd[i] = c; addr[i] = a; wdata[i] = d;
        end else begin
          req[i] = 1'b0;
        end
      end else if (rnd) begin
        if (req[i]) begin
          case ($urandom_range(0, 15))
            0: req[i] = 1'b0;
            1: begin
              pick(rnd, acc, c, a, d);
              cmd[i] = c; addr[i] = a; wdata[i] = d;
            end
            default: ;
          endcase
        end else if (acc < ntx && $urandom_range(0, 2) == 0) begin
          pick(rnd, acc, c, a, d);
          req[i] = 1'b1; cmd[i] = c; addr[i] = a; wdata[i] = d;
        end
      end
      if (resp[i]) begin
        if (q.size() == 0) begin
          check($sformatf("i%0d resp_unexpected cyc%0d", i, cyc), 32'(resp[i]), 0);
        end else begin
          p = q.pop_front();
          check($sformatf("i%0d resp_cyc", i), cyc, p.due);
          if (p.known) check($sformatf("i%0d rdata cyc%0d", i, cyc), rdata[i], p.data);
          outst--;
          if (resp1_cyc < 0) resp1_cyc = cyc;
        end
      end
      if (q.size() != 0 && q[0].due < cyc) begin
        check($sformatf("i%0d resp_missing", i), cyc, q[0].due);
        void'(q.pop_front());
        outst--;
      end
      prev_ack = ack[i];
    end
    req[i] = 1'b0;
    check($sformatf("i%0d stream_accepted", i), acc, ntx);
    check($sformatf("i%0d stream_drained", i), q.size(), 0);
  endtask

  initial begin
    int n;
    int cnt;
    int max_o, ack3_cyc, resp1_cyc;
    vectors = 0;
    miscompares = 0;

    tbl[0]  = '{0, WR, 30'h005,        32'hA5A5_0001, 32'h0};
    tbl[1]  = '{0, RD, 30'h005,        32'h0,         32'hA5A5_0001};
    tbl[2]  = '{0, WR, 30'h000,        32'h1111_0000, 32'h0};
    tbl[3]  = '{0, RD, 30'h100,        32'h0,         32'hDEAD_BEEF};
    tbl[4]  = '{0, WR, 30'h100,        32'h5555_AAAA, 32'h0};
    tbl[5]  = '{0, RD, 30'h000,        32'h0,         32'h1111_0000};
    tbl[6]  = '{0, WR, 30'h0FF,        32'hCAFE_F00D, 32'h0};
    tbl[7]  = '{0, RD, 30'h0FF,        32'h0,         32'hCAFE_F00D};
    tbl[8]  = '{0, RD, 30'h3FFF_FFFF,  32'h0,         32'hDEAD_BEEF};
    tbl[9]  = '{1, WR, 30'h007,        32'h0000_7777, 32'h0};
    tbl[10] = '{1, RD, 30'h007,        32'h0,         32'h0000_7777};
    tbl[11] = '{2, WR, 30'h003,        32'h3333_0003, 32'h0};
    tbl[12] = '{2, RD, 30'h003,        32'h0,         32'h3333_0003};
    tbl[13] = '{2, RD, 30'h2000_0000,  32'h0,         32'hDEAD_BEEF};

    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; cmd[i] = RD; addr[i] = '0; wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("i%0d reset_ack", i), 32'(ack[i]), 0);
      check($sformatf("i%0d reset_resp", i), 32'(resp[i]), 0);
      check($sformatf("i%0d reset_rdata", i), rdata[i], 0);
    end
    rst = 1'b1;

    for (int k = 0; k < 14; k++) begin
      do_txn(tbl[k].inst, tbl[k].c, tbl[k].a, tbl[k].d, tbl[k].exp, $sformatf("vec%0d", k));
    end

    // Abandoned request on the long-wait instance, then a full wait again.
    @(negedge clk);
    req[1] = 1'b1; cmd[1] = RD; addr[1] = 30'h007;
    cnt = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack[1]) cnt++;
    end
    @(negedge clk);
    req[1] = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[1]) cnt++;
    end
    check("abandon_no_ack", cnt, 0);
    do_txn(1, RD, 30'h007, 32'h0, 32'h0000_7777, "abandon_retry");

    // Reset one cycle after a read ack: that read must never respond.
    @(negedge clk);
    req[0] = 1'b1; cmd[0] = RD; addr[0] = 30'h005;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!ack[0] && n < 64);
    req[0] = 1'b0;
    check("rst_mid ack_seen", 32'(ack[0]), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mid ack", 32'(ack[0]), 0);
    check("rst_mid resp", 32'(resp[0]), 0);
    check("rst_mid rdata", rdata[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (resp[0]) cnt++;
    end
    check("rst_mid no_resp", cnt, 0);
    check("rst_mid rdata_after", rdata[0], 0);
    do_txn(0, RD, 30'h005, 32'h0, 32'hA5A5_0001, "rst_after");

    // Outstanding limit on the long-latency instance.
    run_stream(2, 4, 1'b0, max_o, ack3_cyc, resp1_cyc);
    check("stall max_outst", max_o, 2);
    check_true($sformatf("stall ack3 %0d after resp1 %0d", ack3_cyc, resp1_cyc),
               resp1_cyc > 0 && ack3_cyc > resp1_cyc);

    for (int i = 0; i < 3; i++) begin
      run_stream(i, 250, 1'b1, max_o, ack3_cyc, resp1_cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
